// File: rtl/pc_gen_ras_if.sv
// Fetch-PC request/response bundle between branch/trap logic (master) and the PC generator (slave).
// pc_valid qualifies pc: while it is high, pc is a fetch address. There is no ready; the
// consumer is assumed always able to accept the address, and stall is its only back-pressure.
interface pc_gen_ras_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic             stall;
    logic             trap_valid;
    logic [XLEN-1:0]  trap_pc;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             pred_call;
    logic             pred_ret;
    logic [XLEN-1:0]  pred_target;
    logic [XLEN-1:0]  pc;
    logic             pc_valid;
    logic [CNT_W-1:0] ras_count;
    logic             ras_empty;

    modport master (
        output stall, trap_valid, trap_pc, redirect_valid, redirect_pc,
               pred_call, pred_ret, pred_target,
        input  pc, pc_valid, ras_count, ras_empty
    );

    modport slave (
        input  stall, trap_valid, trap_pc, redirect_valid, redirect_pc,
               pred_call, pred_ret, pred_target,
        output pc, pc_valid, ras_count, ras_empty
    );
endinterface

// File: rtl/pc_gen_ras.sv
// Fetch-stage PC generator: fixed-priority next-PC select (trap, redirect, call/return, sequential)
// with a circular return-address stack for return prediction.
module pc_gen_ras #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INST_BYTES   = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    pc_gen_ras_if.slave bus
);
    localparam int              PTR_W      = $clog2(RAS_DEPTH);
    localparam int              CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] STEP       = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  pc_q, pc_nxt;
    logic             pc_valid_q;
    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_nxt;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic [XLEN-1:0]  seq;
    logic             push;

    assign seq = pc_q + STEP;

    // The first edge after reset only raises pc_valid, so RESET_VECTOR itself is fetched.
    always_comb begin
        pc_nxt    = pc_q;
        top_nxt   = top_q;
        count_nxt = count_q;
        push      = 1'b0;
        if (bus.trap_valid) begin
            pc_nxt    = bus.trap_pc & ALIGN_MASK;
            count_nxt = '0;
        end else if (bus.redirect_valid) begin
            pc_nxt = bus.redirect_pc & ALIGN_MASK;
        end else if (bus.stall || !pc_valid_q) begin
            pc_nxt = pc_q;
        end else if (bus.pred_call) begin
            pc_nxt    = bus.pred_target & ALIGN_MASK;
            push      = 1'b1;
            top_nxt   = top_q + 1'b1;
            count_nxt = (count_q == FULL) ? FULL : count_q + 1'b1;
        end else if (bus.pred_ret && (count_q != '0)) begin
            pc_nxt    = ras_mem[top_q] & ALIGN_MASK;
            top_nxt   = top_q - 1'b1;
            count_nxt = count_q - 1'b1;
        end else begin
            pc_nxt = seq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            top_q      <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_nxt;
            pc_valid_q <= 1'b1;
            top_q      <= top_nxt;
            count_q    <= count_nxt;
        end
    end

    // Stack storage carries no reset; entries beyond ras_count are never read.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            ras_mem[top_nxt] <= seq;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_valid  = pc_valid_q;
    assign bus.ras_count = count_q;
    assign bus.ras_empty = (count_q == '0);
endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras: driver pushes hand-computed post-edge state, monitor pops and compares.
module tb_pc_gen_ras;
  localparam int XLEN  = 32;
  localparam int CNT_W = 3;
  localparam int W     = XLEN + 1 + CNT_W + 1;

  logic clk;
  logic rst;

  pc_gen_ras_if #(.XLEN(XLEN), .RAS_DEPTH(4)) bus ();

  pc_gen_ras #(
    .XLEN(XLEN), .RESET_VECTOR(32'h0000_0000), .INST_BYTES(4), .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  int           compared = 0;
  int           mismatched = 0;
  int           step_no = 0;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      int t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {bus.pc, bus.pc_valid, bus.ras_count, bus.ras_empty};
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL step%0d: actual pc=%h valid=%b cnt=%0d empty=%b required pc=%h valid=%b cnt=%0d empty=%b",
                 t, a[W-1 -: XLEN], a[CNT_W+1], a[CNT_W:1], a[0],
                 e[W-1 -: XLEN], e[CNT_W+1], e[CNT_W:1], e[0]);
      end
    end
  end

  // driver: apply one cycle of inputs and the state expected after the next edge
  task automatic step(input logic r, input logic st,
                      input logic tv, input logic [XLEN-1:0] tpc,
                      input logic rv, input logic [XLEN-1:0] rpc,
                      input logic pc_call, input logic pr, input logic [XLEN-1:0] pt,
                      input logic [XLEN-1:0] e_pc, input logic e_v, input logic [CNT_W-1:0] e_cnt);
    @(negedge clk);
    rst                = r;
    bus.stall          = st;
    bus.trap_valid     = tv;
    bus.trap_pc        = tpc;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.pred_call      = pc_call;
    bus.pred_ret       = pr;
    bus.pred_target    = pt;
    step_no++;
    exp_q.push_back({e_pc, e_v, e_cnt, (e_cnt == '0)});
    tag_q.push_back(step_no);
  endtask

  task automatic idle(input logic [XLEN-1:0] e_pc, input logic [CNT_W-1:0] e_cnt);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, e_pc, 1, e_cnt);
  endtask

  task automatic redir(input logic [XLEN-1:0] rpc, input logic [XLEN-1:0] e_pc, input logic [CNT_W-1:0] e_cnt);
    step(0, 0, 0, 0, 1, rpc, 0, 0, 0, e_pc, 1, e_cnt);
  endtask

  task automatic call(input logic [XLEN-1:0] pt, input logic [XLEN-1:0] e_pc, input logic [CNT_W-1:0] e_cnt);
    step(0, 0, 0, 0, 0, 0, 1, 0, pt, e_pc, 1, e_cnt);
  endtask

  task automatic ret(input logic [XLEN-1:0] e_pc, input logic [CNT_W-1:0] e_cnt);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, e_pc, 1, e_cnt);
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 0; bus.trap_valid = 0; bus.trap_pc = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0;
    bus.pred_call = 0; bus.pred_ret = 0; bus.pred_target = 0;

    // reset and sequential fetch; RESET_VECTOR is fetched on the first valid cycle
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    idle(32'h0, 0);
    idle(32'h4, 0);
    idle(32'h8, 0);
    idle(32'hC, 0);
    // stall holds pc, even with a call pending
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'hC, 1, 0);
    step(0, 1, 0, 0, 0, 0, 1, 0, 32'h700, 32'hC, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'hC, 1, 0);
    idle(32'h10, 0);

    // priority: trap beats redirect, stall and call, and clears the RAS
    redir(32'h100, 32'h100, 0);
    call(32'h300, 32'h300, 1);
    redir(32'h100, 32'h100, 1);
    step(0, 1, 1, 32'h800, 1, 32'h200, 1, 0, 32'h500, 32'h800, 1, 0);
    step(0, 1, 0, 0, 1, 32'h200, 0, 1, 0, 32'h200, 1, 0);

    // call / return / empty return
    redir(32'h40, 32'h40, 0);
    call(32'h1000, 32'h1000, 1);
    idle(32'h1004, 1);
    ret(32'h44, 0);
    ret(32'h48, 0);

    // overflow: five nested calls, four returns, fifth falls through
    redir(32'h10, 32'h10, 0);
    call(32'h20, 32'h20, 1);
    call(32'h30, 32'h30, 2);
    call(32'h40, 32'h40, 3);
    call(32'h50, 32'h50, 4);
    call(32'h60, 32'h60, 4);
    ret(32'h54, 3);
    ret(32'h44, 2);
    ret(32'h34, 1);
    ret(32'h24, 0);
    ret(32'h28, 0);

    // alignment, call-wins-over-ret, trap with occupied RAS, wraparound
    redir(32'h103, 32'h100, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 32'h2002, 32'h2000, 1, 1);
    call(32'h3000, 32'h3000, 2);
    call(32'h4000, 32'h4000, 3);
    step(0, 0, 1, 32'h902, 0, 0, 0, 0, 0, 32'h900, 1, 0);
    redir(32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
    idle(32'h0, 0);
    idle(32'h4, 0);

    // reset in the middle of a call sequence overrides everything
    call(32'h5000, 32'h5000, 1);
    call(32'h6000, 32'h6000, 2);
    step(1, 1, 1, 32'h900, 1, 32'h200, 1, 0, 32'h7000, 32'h0, 0, 0);
    idle(32'h0, 0);
    idle(32'h4, 0);
    ret(32'h8, 0);

    @(negedge clk);
    bus.pred_ret = 0;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: actual %0d pending required 0 pending", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
Parametrised fetch-stage PC generator. It succeeds the single-register PC plus adder.
- Holds the fetch PC with stall and hold behaviour.
- Arbitrates next-PC sources by fixed priority: trap, execute-stage redirect, predicted call/return, sequential.
- Contains a circular return-address stack (RAS) for return prediction.
- Sits between the branch/trap logic and instruction memory address.

Parameters:
XLEN, 32, width of PC and all address ports
RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
INST_BYTES, 4, sequential increment; 2 or 4 only; targets aligned to this
RAS_DEPTH, 4, RAS entries; power of two, >= 2

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold PC and RAS when no trap/redirect
trap_valid  in  1  trap/exception redirect request
trap_pc  in  XLEN  trap handler address
redirect_valid  in  1  execute-stage mispredict/jump correction
redirect_pc  in  XLEN  corrected target
pred_call  in  1  predecoder: instruction at pc is a call
pred_ret  in  1  predecoder: instruction at pc is a return
pred_target  in  XLEN  predicted call target
pc  out  XLEN  current fetch address
pc_valid  out  1  pc is a valid fetch address
ras_count  out  $clog2(RAS_DEPTH+1)  occupied RAS entries
ras_empty  out  1  ras_count == 0

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk. While rst=1 at an edge:
  - pc <= RESET_VECTOR, pc_valid <= 0.
  - RAS pointer and ras_count <= 0; RAS contents don't-care.
- pc_valid is registered: it becomes 1 on the first edge with rst=0 and stays 1.
- rst asserted mid-operation overrides every other input that cycle.
- seq = pc + INST_BYTES, modulo 2^XLEN. 0xFFFF_FFFC + 4 wraps to 0.
- Alignment: low log2(INST_BYTES) bits of trap_pc, redirect_pc, pred_target and popped RAS values are forced to 0 before use.
- Next-PC priority, evaluated each cycle with rst=0:
  1. trap_valid: pc <= trap_pc. RAS cleared (ras_count <= 0). Ignores stall and pred_*.
  2. redirect_valid: pc <= redirect_pc. RAS unchanged. Ignores stall and pred_*.
  3. stall: pc and RAS hold.
  4. pred_call: pc <= pred_target; push seq onto RAS. pred_ret is ignored if also set.
  5. pred_ret with ras_count > 0: pc <= top entry; pop.
  6. pred_ret with ras_count == 0: pc <= seq; no pop; ras_count stays 0.
  7. Otherwise: pc <= seq.
- Latency: every selected source appears on pc one edge later. No combinational path from inputs to pc.
- RAS is circular with a top pointer.
  - Push: pointer increments (mod RAS_DEPTH), entry written, ras_count saturates at RAS_DEPTH.
  - Push when full overwrites the oldest entry.
  - Pop: returns the entry at top, pointer decrements, ras_count decrements.
  - After overflow, more than RAS_DEPTH consecutive pops return stale wrapped entries only while ras_count > 0. Once count reaches 0, pops stop.
- Simultaneous trap_valid and redirect_valid: trap wins.
- stall with trap/redirect: the redirect is taken (the flush must not be lost).

Test Plan:
- Reset/sequence: rst=1 for 2 cycles, then 0, no other inputs -> pc=0, pc_valid=0 during reset; next edge pc_valid=1, then pc=4, 8, 12. Stall 3 cycles at pc=12 -> pc holds 12, then 16.
- Priority: at pc=0x100 assert trap_valid (trap_pc=0x800), redirect_valid (0x200), stall, pred_call together -> pc=0x800, ras_count=0. Redirect+stall alone -> pc=redirect_pc.
- Call/return: pc=0x40, pred_call, pred_target=0x1000 -> pc=0x1000, ras_count=1. Later pred_ret -> pc=0x44, ras_count=0. Next pred_ret on empty RAS -> pc=seq.
- Overflow: RAS_DEPTH=4, 5 nested calls from 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_count=4. Four returns yield 0x54, 0x44, 0x34, 0x24; a fifth return falls through to sequential.
- Boundaries: pc=0xFFFF_FFFC sequential -> pc=0. redirect_pc=0x103 with INST_BYTES=4 -> pc=0x100. Trap with ras_count=3 -> ras_empty=1 next cycle. rst mid-call-sequence -> pc=RESET_VECTOR, ras_count=0.
